// File: rtl/dma_chan_sched_pkg.sv
// dma_chan_sched_pkg: scheduler states, channel index type and perf counter widths
package dma_chan_sched_pkg;
  localparam int NUM_CH_MAX = 8;
  localparam int PERF_BEAT_W = 32;
  localparam int PERF_XFER_W = 16;
  typedef enum logic [1:0] {IDLE, GO, XFER, DRAIN} state_t;
  typedef logic [$clog2(NUM_CH_MAX)-1:0] ch_idx_t;
endpackage

// File: rtl/dma_chan_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from ptr; next_ptr moves past the winner on advance
module rr_arbiter
  import dma_chan_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  ch_idx_t      ptr,
  input  logic         advance,
  output logic [N-1:0] grant,
  output ch_idx_t      next_ptr
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  logic [IW-1:0] k;
  always_comb begin
    grant = '0;
    next_ptr = ptr;
    k = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (grant == '0 && req[k]) begin
        grant[k] = 1'b1;
        next_ptr = advance ? ch_idx_t'((int'(k) + 1) % N) : ptr;
      end
    end
  end
endmodule

// File: rtl/dma_chan_sched.sv
// dma_chan_sched: round-robin scheduler granting host DMA read/write channels to NUM_CH clients.
// Define DMA_CHAN_SCHED_PERF_EN to add per-channel beat/transfer counters with perf_clr.
module dma_chan_sched
  import dma_chan_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 64,
  parameter int SIZE_W = 16,
  parameter int DATA_W = 512,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef DMA_CHAN_SCHED_PERF_EN
  input  logic                     perf_clr,
  output logic [NUM_CH*PERF_BEAT_W-1:0] perf_beats,
  output logic [NUM_CH*PERF_XFER_W-1:0] perf_xfers,
`endif
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*SIZE_W-1:0] req_size,
  output logic [NUM_CH-1:0]        ch_rd_valid,
  input  logic [NUM_CH-1:0]        ch_rd_ready,
  output logic [DATA_W-1:0]        ch_rd_data,
  input  logic [NUM_CH-1:0]        ch_wr_valid,
  output logic [NUM_CH-1:0]        ch_wr_ready,
  input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]        done_pulse,
  output logic                     busy,
  output logic [CW-1:0]            active_ch,
  output logic                     dma_rd_go,
  output logic                     dma_rd_en,
  output logic [ADDR_W-1:0]        dma_rd_addr,
  output logic [SIZE_W-1:0]        dma_rd_size,
  input  logic [DATA_W-1:0]        dma_rd_data,
  input  logic                     dma_empty,
  input  logic                     dma_rd_done,
  output logic                     dma_wr_go,
  output logic                     dma_wr_en,
  output logic [ADDR_W-1:0]        dma_wr_addr,
  output logic [SIZE_W-1:0]        dma_wr_size,
  output logic [DATA_W-1:0]        dma_wr_data,
  input  logic                     dma_full,
  input  logic                     dma_wr_done
);
  state_t state, state_nx;
  logic wr_q, arb_en, take, rd_ok, wr_ok, en, last, done_in;
  logic [ADDR_W-1:0] addr_q;
  logic [SIZE_W-1:0] size_q, beats, win_size;
  logic [CW-1:0] act_q, grant_idx;
  logic [NUM_CH-1:0] grant, act_oh, done_nx;
  ch_idx_t ptr, ptr_nx;
  // no grant while a done pulse is out, so the next grant lands the cycle after it
  assign arb_en = state == IDLE && done_pulse == '0;
  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req(arb_en ? req_valid : '0), .ptr(ptr), .advance(arb_en), .grant(grant), .next_ptr(ptr_nx)
  );
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) if (grant[i]) grant_idx = CW'(i);
  end
  assign take = |grant;
  assign win_size = req_size[int'(grant_idx)*SIZE_W +: SIZE_W];
  assign act_oh = NUM_CH'(1) << act_q;
  assign rd_ok = state == XFER && !wr_q && !dma_empty && beats < size_q;
  assign wr_ok = state == XFER && wr_q && !dma_full && beats < size_q;
  assign ch_rd_valid = rd_ok ? act_oh : '0;
  assign ch_wr_ready = wr_ok ? act_oh : '0;
  assign dma_rd_en = rd_ok && ch_rd_ready[act_q];
  assign dma_wr_en = wr_ok && ch_wr_valid[act_q];
  assign en = dma_rd_en || dma_wr_en;
  assign last = en && beats + SIZE_W'(1) == size_q;
  assign done_in = wr_q ? dma_wr_done : dma_rd_done;
  assign done_nx = take && win_size == '0 ? grant : (state == DRAIN && done_in ? act_oh : '0);
  assign ch_rd_data = dma_rd_data;
  assign dma_wr_data = ch_wr_data[int'(act_q)*DATA_W +: DATA_W];
  assign dma_rd_go = state == GO && !wr_q;
  assign dma_wr_go = state == GO && wr_q;
  assign dma_rd_addr = addr_q;
  assign dma_wr_addr = addr_q;
  assign dma_rd_size = size_q;
  assign dma_wr_size = size_q;
  assign req_ready = grant;
  assign busy = state != IDLE;
  assign active_ch = act_q;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = take && win_size != '0 ? GO : IDLE;
      GO:      state_nx = XFER;
      XFER:    state_nx = last ? DRAIN : XFER;
      DRAIN:   state_nx = done_in ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_q <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      act_q <= '0;
      beats <= '0;
      ptr <= '0;
      done_pulse <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      done_pulse <= done_nx;
      if (take) begin
        wr_q <= req_wr[grant_idx];
        addr_q <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        size_q <= win_size;
        act_q <= grant_idx;
        beats <= '0;
      end else if (en) beats <= beats + SIZE_W'(1);
    end
`ifdef DMA_CHAN_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_beats <= '0;
      perf_xfers <= '0;
    end else if (perf_clr) begin
      perf_beats <= '0;
      perf_xfers <= '0;
    end else
      for (int c = 0; c < NUM_CH; c++) begin
        if (en && act_q == CW'(c))
          perf_beats[c*PERF_BEAT_W +: PERF_BEAT_W] <= perf_beats[c*PERF_BEAT_W +: PERF_BEAT_W] + PERF_BEAT_W'(1);
        if (done_nx[c])
          perf_xfers[c*PERF_XFER_W +: PERF_XFER_W] <= perf_xfers[c*PERF_XFER_W +: PERF_XFER_W] + PERF_XFER_W'(1);
      end
`endif
endmodule

// File: tb/tb_dma_chan_sched.sv
// tb_dma_chan_sched: directed sequence with randomized data/flow control, checked against a transaction-level model
module tb_dma_chan_sched;
  localparam int N = 4, AW = 64, SW = 16, DW = 512, CW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, req_wr, ch_rd_valid, ch_rd_ready, ch_wr_valid, ch_wr_ready, done_pulse;
  logic [N*AW-1:0] req_addr;
  logic [N*SW-1:0] req_size;
  logic [DW-1:0] ch_rd_data, dma_rd_data, dma_wr_data;
  logic [N*DW-1:0] ch_wr_data;
  logic busy, dma_rd_go, dma_rd_en, dma_empty, dma_rd_done, dma_wr_go, dma_wr_en, dma_full, dma_wr_done;
  logic [CW-1:0] active_ch;
  logic [AW-1:0] dma_rd_addr, dma_wr_addr;
  logic [SW-1:0] dma_rd_size, dma_wr_size;
`ifdef DMA_CHAN_SCHED_PERF_EN
  logic perf_clr;
  logic [N*32-1:0] perf_beats;
  logic [N*16-1:0] perf_xfers;
`endif
  int vec = 0, miscmp = 0, ptr_m = 0;

  dma_chan_sched #(.NUM_CH(N), .ADDR_W(AW), .SIZE_W(SW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef DMA_CHAN_SCHED_PERF_EN
    .perf_clr(perf_clr), .perf_beats(perf_beats), .perf_xfers(perf_xfers),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
    .ch_rd_valid(ch_rd_valid), .ch_rd_ready(ch_rd_ready), .ch_rd_data(ch_rd_data),
    .ch_wr_valid(ch_wr_valid), .ch_wr_ready(ch_wr_ready), .ch_wr_data(ch_wr_data),
    .done_pulse(done_pulse), .busy(busy), .active_ch(active_ch),
    .dma_rd_go(dma_rd_go), .dma_rd_en(dma_rd_en), .dma_rd_addr(dma_rd_addr), .dma_rd_size(dma_rd_size),
    .dma_rd_data(dma_rd_data), .dma_empty(dma_empty), .dma_rd_done(dma_rd_done),
    .dma_wr_go(dma_wr_go), .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr), .dma_wr_size(dma_wr_size),
    .dma_wr_data(dma_wr_data), .dma_full(dma_full), .dma_wr_done(dma_wr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // spec rule: first requester found scanning upward from the channel after the last grant
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic chk_reset(input string t);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_req_ready"}, req_ready, 0);
    chk({t, "_ch_rd_valid"}, ch_rd_valid, 0);
    chk({t, "_ch_wr_ready"}, ch_wr_ready, 0);
    chk({t, "_done"}, done_pulse, 0);
    chk({t, "_go"}, {dma_rd_go, dma_wr_go}, 0);
    chk({t, "_en"}, {dma_rd_en, dma_wr_en}, 0);
    chk({t, "_addr"}, {dma_rd_addr, dma_wr_addr}, 0);
    chk({t, "_size"}, {dma_rd_size, dma_wr_size}, 0);
    chk({t, "_active_ch"}, active_ch, 0);
  endtask

  // one descriptor on channel ch; abort_after>0 returns mid-transfer once that many beats moved
  task automatic xfer(input int ch, input logic wr, input logic [AW-1:0] addr, input int size,
                      input int abort_after, input bit toggle_full);
    int beats, cyc, n_en;
    logic [N-1:0] oh;
    logic ok, exp_en;
    oh = N'(1) << ch;
    @(negedge clk);
    req_valid = oh;
    req_wr = wr ? oh : '0;
    req_addr[ch*AW +: AW] = addr;
    req_size[ch*SW +: SW] = SW'(size);
    #1 chk("req_ready", req_ready, oh);
    ptr_m = (ch + 1) % N;
    @(negedge clk);
    req_valid = '0;
    if (wr) dma_wr_done = 1'b1; else dma_rd_done = 1'b1;
    #1;
    chk("rd_go", dma_rd_go, !wr);
    chk("wr_go", dma_wr_go, wr);
    chk("go_addr", wr ? dma_wr_addr : dma_rd_addr, addr);
    chk("go_size", wr ? dma_wr_size : dma_rd_size, size);
    chk("active_ch", active_ch, ch);
    chk("busy_go", busy, 1);
    beats = 0; cyc = 0; n_en = 0;
    while (beats < size && cyc < 200) begin
      @(negedge clk);
      dma_rd_done = 1'b0;
      dma_wr_done = 1'b0;
      if (abort_after > 0 && beats == abort_after) return;
      dma_empty = 1'($urandom_range(0, 1));
      dma_full = toggle_full ? cyc[0] : 1'($urandom_range(0, 1));
      ch_rd_ready = N'($urandom);
      ch_wr_valid = N'($urandom);
      dma_rd_data = rnd_line();
      for (int i = 0; i < N; i++) ch_wr_data[i*DW +: DW] = rnd_line();
      #1;
      ok = wr ? !dma_full : !dma_empty;
      exp_en = ok && (wr ? ch_wr_valid[ch] : ch_rd_ready[ch]);
      chk("ch_rd_valid", ch_rd_valid, (!wr && ok) ? oh : '0);
      chk("ch_wr_ready", ch_wr_ready, (wr && ok) ? oh : '0);
      chk("dma_rd_en", dma_rd_en, !wr && exp_en);
      chk("dma_wr_en", dma_wr_en, wr && exp_en);
      if (wr) chk("dma_wr_data", dma_wr_data, ch_wr_data[ch*DW +: DW]);
      else chk("ch_rd_data", ch_rd_data, dma_rd_data);
      chk("done_in_xfer", done_pulse, 0);
      n_en += int'(dma_rd_en) + int'(dma_wr_en);
      beats += int'(exp_en);
      cyc++;
    end
    chk("xfer_timeout", beats, size);
    // tempt the DUT with open flow control while it waits for done
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      dma_empty = 1'b0; dma_full = 1'b0; ch_rd_ready = '1; ch_wr_valid = '1;
      #1;
      chk("drain_busy", busy, 1);
      chk("drain_no_beat", {ch_rd_valid, ch_wr_ready}, 0);
      chk("drain_done", done_pulse, 0);
      n_en += int'(dma_rd_en) + int'(dma_wr_en);
    end
    chk("en_count", n_en, size);
    @(negedge clk);
    if (wr) dma_wr_done = 1'b1; else dma_rd_done = 1'b1;
    #1 chk("done_early", done_pulse, 0);
    @(negedge clk);
    dma_rd_done = 1'b0; dma_wr_done = 1'b0;
    #1;
    chk("done_pulse", done_pulse, oh);
    chk("busy_after", busy, 0);
    @(negedge clk);
    #1 chk("done_once", done_pulse, 0);
  endtask

  // size-0 descriptors on every channel in v, checking round-robin grant order
  task automatic rr_round(input logic [N-1:0] v);
    int w;
    req_size = '0;
    while (v != '0) begin
      @(negedge clk);
      req_valid = v;
      req_wr = N'($urandom);
      #1;
      w = rr_pick(v, ptr_m);
      chk("rr_grant", req_ready, N'(1) << w);
      ptr_m = (w + 1) % N;
      v[w] = 1'b0;
      @(negedge clk);
      req_valid = v;
      #1;
      chk("size0_done", done_pulse, N'(1) << w);
      chk("size0_no_go", {dma_rd_go, dma_wr_go}, 0);
      chk("size0_idle", busy, 0);
      chk("grant_held_off", req_ready, 0);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    req_valid = '0; req_wr = '0; req_addr = '0; req_size = '0;
    ch_rd_ready = '0; ch_wr_valid = '0; ch_wr_data = '0; dma_rd_data = '0;
    dma_empty = 1'b1; dma_full = 1'b1; dma_rd_done = 1'b0; dma_wr_done = 1'b0;
`ifdef DMA_CHAN_SCHED_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1 chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk_reset("post_rst");

    xfer(1, 1'b0, 64'h1000, 3, 0, 1'b0);

    rst_n = 1'b0;
    ptr_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_round(4'hF);
    rr_round(4'hF);
    repeat (6) rr_round(N'($urandom_range(1, (1 << N) - 1)));

    xfer(2, 1'b1, {$urandom, $urandom}, 4, 0, 1'b1);
    repeat (8) xfer($urandom_range(0, N - 1), 1'($urandom), {$urandom, $urandom}, $urandom_range(1, 6), 0, 1'b0);

    xfer(2, 1'b0, 64'hdead_0000, 5, 2, 1'b0);
    rst_n = 1'b0;
    ptr_m = 0;
    #1 chk_reset("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    rr_round(4'b1001);

`ifdef DMA_CHAN_SCHED_PERF_EN
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    repeat (2) xfer(3, 1'b0, 64'h2000, 5, 0, 1'b0);
    chk("perf_beats3", perf_beats[3*32 +: 32], 10);
    chk("perf_xfers3", perf_xfers[3*16 +: 16], 2);
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1;
    chk("perf_beats_clr", perf_beats, 0);
    chk("perf_xfers_clr", perf_xfers, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
